// File: rtl/execute_writeback_arbiter_if.sv
// Execute -> writeback bundle interface.
//   in_valid/in_ready/in_data/in_rob_idx : per-FU result channels (FU side drives valid/data)
//   wb_valid/wb_data/wb_rob_idx/wb_src   : writeback slots toward ROB/commit (never stall)
// master modport: the execute-unit / consumer side (drives channels, observes slots).
// slave modport : the arbiter.
interface execute_writeback_arbiter_if #(
   parameter int FU_NUM    = 7,
   parameter int WB_NUM    = 4,
   parameter int DATA_W    = 96,
   parameter int ROB_IDX_W = 6,
   parameter int SRC_W     = (FU_NUM > 1) ? $clog2(FU_NUM) : 1
);
   logic [FU_NUM-1:0]           in_valid;
   logic [FU_NUM-1:0]           in_ready;
   logic [FU_NUM*DATA_W-1:0]    in_data;
   logic [FU_NUM*ROB_IDX_W-1:0] in_rob_idx;
   logic [WB_NUM-1:0]           wb_valid;
   logic [WB_NUM*DATA_W-1:0]    wb_data;
   logic [WB_NUM*ROB_IDX_W-1:0] wb_rob_idx;
   logic [WB_NUM*SRC_W-1:0]     wb_src;

   modport master (
      output in_valid, in_data, in_rob_idx,
      input  in_ready, wb_valid, wb_data, wb_rob_idx, wb_src
   );

   modport slave (
      input  in_valid, in_data, in_rob_idx,
      output in_ready, wb_valid, wb_data, wb_rob_idx, wb_src
   );
endinterface

// File: rtl/execute_writeback_arbiter.sv
// Execute-to-writeback arbiter.
// Each FU channel pushes into its own small FIFO; a rotating-priority scan over the
// FIFO heads grants up to WB_NUM channels per cycle to writeback slots 0..g-1.
// Ports:
//   clk_i    : clock
//   reset_i  : synchronous active-high reset (wins over flush)
//   flush_i  : synchronous pipeline flush, empties every FIFO and rewinds rr pointer
//   bus      : execute_writeback_arbiter_if.slave (channel inputs, writeback slots)

// Per-channel FIFO: push/pop may coincide; clr_i empties it synchronously.
module ewa_chan_fifo #(
   parameter int W     = 102,
   parameter int DEPTH = 2,
   parameter int PTR_W = $clog2(DEPTH),
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             clr_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [W-1:0]     din_i,
   output logic [W-1:0]     dout_o,
   output logic [CNT_W-1:0] count_o
);
   logic [W-1:0]     mem_q [DEPTH];
   logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      // DEPTH is a power of two, so pointer overflow is the wrap.
      if (push_i) wr_d = wr_q + PTR_W'(1);
      if (pop_i)  rd_d = rd_q + PTR_W'(1);
      if (push_i && !pop_i) cnt_d = cnt_q + CNT_W'(1);
      if (!push_i && pop_i) cnt_d = cnt_q - CNT_W'(1);
   end

   always_ff @(posedge clk_i) begin
      if (reset_i || clr_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   // Payload storage needs no reset; validity is tracked by cnt_q.
   always_ff @(posedge clk_i) begin
      if (push_i) mem_q[wr_q] <= din_i;
   end

   assign dout_o  = mem_q[rd_q];
   assign count_o = cnt_q;
endmodule

module execute_writeback_arbiter #(
   parameter int FU_NUM     = 7,
   parameter int WB_NUM     = 4,
   parameter int DATA_W     = 96,
   parameter int ROB_IDX_W  = 6,
   parameter int FIFO_DEPTH = 2
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic flush_i,
   execute_writeback_arbiter_if.slave bus
);
   localparam int SRC_W = (FU_NUM > 1) ? $clog2(FU_NUM) : 1;
   localparam int ENT_W = DATA_W + ROB_IDX_W;
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic                            active;
   logic [FU_NUM-1:0]               push, pop, nempty, ready;
   logic [FU_NUM-1:0][ENT_W-1:0]    head;
   logic [FU_NUM-1:0][CNT_W-1:0]    cnt;
   logic [WB_NUM-1:0]               slot_vld;
   logic [WB_NUM-1:0][SRC_W-1:0]    slot_sel;
   logic [SRC_W-1:0]                rr_q, rr_d;

   // Neither side moves during reset or flush.
   assign active = !reset_i && !flush_i;

   generate
      for (genvar i = 0; i < FU_NUM; i++) begin : g_ch
         // Ready looks only at the registered count, never at this cycle's pop.
         assign ready[i]  = active && (cnt[i] < CNT_W'(FIFO_DEPTH));
         assign push[i]   = bus.in_valid[i] && ready[i];
         assign nempty[i] = (cnt[i] != '0);

         ewa_chan_fifo #(.W(ENT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
            .clk_i   (clk_i),
            .reset_i (reset_i),
            .clr_i   (flush_i),
            .push_i  (push[i]),
            .pop_i   (pop[i]),
            .din_i   ({bus.in_rob_idx[i*ROB_IDX_W +: ROB_IDX_W],
                       bus.in_data[i*DATA_W +: DATA_W]}),
            .dout_o  (head[i]),
            .count_o (cnt[i])
         );
      end
   endgenerate

   assign bus.in_ready = ready;

   // Rotating scan starting at rr_q; the g-th non-empty channel found lands in slot g.
   // Loops compare against constant loop indices so every select is static.
   always_comb begin
      int ch;
      int g;
      ch       = 0;
      g        = 0;
      pop      = '0;
      slot_vld = '0;
      slot_sel = '0;
      rr_d     = rr_q;
      for (int off = 0; off < FU_NUM; off++) begin
         ch = int'(rr_q) + off;
         if (ch >= FU_NUM) ch = ch - FU_NUM;
         for (int c = 0; c < FU_NUM; c++) begin
            if (c == ch && active && nempty[c] && g < WB_NUM) begin
               for (int k = 0; k < WB_NUM; k++) begin
                  if (k == g) begin
                     slot_vld[k] = 1'b1;
                     slot_sel[k] = SRC_W'(c);
                  end
               end
               pop[c] = 1'b1;
               // Next scan starts just past the last channel granted.
               rr_d   = (c == FU_NUM - 1) ? '0 : SRC_W'(c + 1);
               g      = g + 1;
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i || flush_i) rr_q <= '0;
      else                    rr_q <= rr_d;
   end

   generate
      for (genvar k = 0; k < WB_NUM; k++) begin : g_slot
         assign bus.wb_valid[k]                           = slot_vld[k];
         assign bus.wb_data[k*DATA_W +: DATA_W]           = head[slot_sel[k]][DATA_W-1:0];
         assign bus.wb_rob_idx[k*ROB_IDX_W +: ROB_IDX_W]  = head[slot_sel[k]][ENT_W-1:DATA_W];
         assign bus.wb_src[k*SRC_W +: SRC_W]              = slot_sel[k];
      end
   endgenerate
endmodule

// File: tb/tb_execute_writeback_arbiter.sv
// Randomized bench for execute_writeback_arbiter against a queue-based reference model.
module tb_execute_writeback_arbiter;
   localparam int FU  = 7;
   localparam int WB  = 4;
   localparam int DW  = 96;
   localparam int TW  = 6;
   localparam int DEP = 2;
   localparam int SW  = 3;

   typedef logic [DW+TW-1:0] ent_t;   // {data, tag}

   logic clk = 1'b0;
   logic rst, fl;
   always #5 clk = ~clk;

   execute_writeback_arbiter_if #(.FU_NUM(FU), .WB_NUM(WB), .DATA_W(DW), .ROB_IDX_W(TW)) bus ();

   execute_writeback_arbiter #(
      .FU_NUM(FU), .WB_NUM(WB), .DATA_W(DW), .ROB_IDX_W(TW), .FIFO_DEPTH(DEP)
   ) dut (
      .clk_i   (clk),
      .reset_i (rst),
      .flush_i (fl),
      .bus     (bus)
   );

   int errs = 0;
   int checks = 0;

   ent_t       mq [FU][$];
   int         rr = 0;
   int         g;
   int         gch [WB];
   logic [FU-1:0] exp_rdy;
   int         pops [FU];
   int         miss [FU];
   int         max_miss;
   bit         count_en = 1'b0;

   task automatic chk(string tag, logic [127:0] got, logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic set_in(logic [FU-1:0] v);
      for (int i = 0; i < FU; i++) begin
         bus.in_data[i*DW +: DW]   = {$urandom(), $urandom(), $urandom()};
         bus.in_rob_idx[i*TW +: TW] = TW'($urandom());
      end
      bus.in_valid = v;
   endtask

   // Compare this cycle's DUT outputs with the model (at negedge).
   task automatic sample();
      logic [WB-1:0] vm;
      int ch;
      @(negedge clk);
      exp_rdy = '0;
      for (int i = 0; i < FU; i++)
         if (!rst && !fl && mq[i].size() < DEP) exp_rdy[i] = 1'b1;
      g = 0;
      for (int off = 0; off < FU; off++) begin
         ch = (rr + off) % FU;
         if (!rst && !fl && mq[ch].size() > 0 && g < WB) begin
            gch[g] = ch;
            g++;
         end
      end
      vm = '0;
      for (int k = 0; k < g; k++) vm[k] = 1'b1;
      chk("in_ready", bus.in_ready, exp_rdy);
      chk("wb_valid", bus.wb_valid, vm);
      for (int k = 0; k < g; k++) begin
         chk("wb_src", bus.wb_src[k*SW +: SW], gch[k]);
         chk("wb_rob_idx", bus.wb_rob_idx[k*TW +: TW], mq[gch[k]][0][TW-1:0]);
         chk("wb_data", bus.wb_data[k*DW +: DW], mq[gch[k]][0][DW+TW-1:TW]);
      end
   endtask

   // Advance the model across the closing edge, then step past it.
   task automatic adv();
      bit gr [FU];
      for (int i = 0; i < FU; i++) gr[i] = 1'b0;
      if (rst || fl) begin
         for (int i = 0; i < FU; i++) mq[i].delete();
         rr = 0;
      end else begin
         for (int k = 0; k < g; k++) begin
            void'(mq[gch[k]].pop_front());
            gr[gch[k]] = 1'b1;
            if (count_en) pops[gch[k]]++;
         end
         if (g > 0) rr = (gch[g-1] + 1) % FU;
         for (int i = 0; i < FU; i++)
            if (bus.in_valid[i] && exp_rdy[i])
               mq[i].push_back({bus.in_data[i*DW +: DW], bus.in_rob_idx[i*TW +: TW]});
      end
      if (count_en)
         for (int i = 0; i < FU; i++) begin
            miss[i] = gr[i] ? 0 : miss[i] + 1;
            if (miss[i] > max_miss) max_miss = miss[i];
         end
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      fl  = 1'b0;
      set_in('1);
      // Reset held with all channels offering.
      repeat (3) begin sample(); adv(); end
      rst = 1'b0;
      set_in('0);
      sample();
      chk("rdy_after_rst", bus.in_ready, 7'h7F);
      adv();

      // One push per channel, tags 0..6.
      set_in('1);
      for (int i = 0; i < FU; i++) bus.in_rob_idx[i*TW +: TW] = TW'(i);
      sample(); adv();
      set_in('0);
      sample();
      chk("burst_c1_vld", bus.wb_valid, 4'hF);
      chk("burst_c1_src", bus.wb_src, 12'h688);
      adv();
      sample();
      chk("burst_c2_vld", bus.wb_valid, 4'h7);
      chk("burst_c2_src", bus.wb_src[3*SW-1:0], 9'h1AC);
      adv();
      sample();
      chk("burst_c3_vld", bus.wb_valid, 4'h0);
      adv();

      // Saturating load: 70 measured cycles after the first push cycle.
      for (int i = 0; i < FU; i++) begin pops[i] = 0; miss[i] = 0; end
      max_miss = 0;
      for (int c = 0; c <= 70; c++) begin
         set_in('1);
         count_en = (c >= 1);
         sample(); adv();
      end
      count_en = 1'b0;
      for (int i = 0; i < FU; i++) chk("pops_per_ch", pops[i], 40);
      chk("max_gap_ok", (max_miss <= 1), 1);

      // Flush with full FIFOs.
      fl = 1'b1;
      set_in('1);
      sample();
      chk("flush_rdy", bus.in_ready, 7'h00);
      chk("flush_vld", bus.wb_valid, 4'h0);
      adv();
      fl = 1'b0;
      set_in('0);
      sample();
      chk("post_flush_vld", bus.wb_valid, 4'h0);
      adv();
      set_in(7'b0100000);
      bus.in_rob_idx[5*TW +: TW] = TW'(9);
      sample(); adv();
      set_in('0);
      sample();
      chk("ch5_vld", bus.wb_valid, 4'h1);
      chk("ch5_src", bus.wb_src[SW-1:0], 3'd5);
      chk("ch5_tag", bus.wb_rob_idx[TW-1:0], 6'd9);
      adv();

      // Push collides with reset: entry must be dropped.
      rst = 1'b1;
      set_in(7'b0001000);
      sample();
      chk("rst_push_rdy", bus.in_ready, 7'h00);
      adv();
      set_in('0);
      sample(); adv();
      rst = 1'b0;
      repeat (2) begin
         sample();
         chk("rst_push_gone", bus.wb_valid, 4'h0);
         adv();
      end

      // Random traffic with occasional flush/reset.
      for (int c = 0; c < 400; c++) begin
         rst = ($urandom_range(59) == 0);
         fl  = ($urandom_range(24) == 0);
         set_in(FU'($urandom()));
         sample(); adv();
      end
      rst = 1'b0;
      fl  = 1'b0;
      set_in('0);
      repeat (4) begin sample(); adv(); end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
